// File: rtl/regfile_pkg.sv
// Shared register-file constants and types used by the write-port arbiter.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd31;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotates the request vector so the
// pointer position lands at bit 0, then scans for the first set bit.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0]     idx_sum;
  logic               found;

  always_comb begin
    rot     = NUM_REQ'({req, req} >> ptr);
    idx_sum = '0;
    found   = 1'b0;
    gnt     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found   = 1'b1;
        idx_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      end
    end
    // Map the rotated position back to an absolute index, modulo NUM_REQ.
    if (idx_sum >= NUM_REQ_W) begin
      idx_sum = idx_sum - NUM_REQ_W;
    end
    gnt_idx = idx_sum[IDX_W-1:0];
    if (found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among NUM_REQ requesters with
// round-robin arbitration and a single registered output beat.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 64,
  parameter  int ADDR_W  = REG_ADDR_W,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      wr_stall,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [IDX_W-1:0]          grant_id
);

  logic               out_full_q, out_full_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               can_accept;
  logic               grant;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // A beat may be accepted when the output register is empty or draining now.
  assign can_accept = !out_full_q || !wr_stall;
  assign req_ready  = (reset || !can_accept) ? '0 : arb_gnt;
  assign grant      = |req_ready;
  assign sel_addr   = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
  assign sel_data   = req_data[int'(arb_idx)*DATA_W +: DATA_W];

  always_comb begin
    out_full_d = out_full_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant) begin
      wr_addr_d  = sel_addr;
      wr_data_d  = sel_data;
      grant_id_d = arb_idx;
      out_full_d = (sel_addr != ADDR_W'(ZERO_REG));
      rr_ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end else if (out_full_q && !wr_stall) begin
      out_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_full_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      out_full_q <= out_full_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign wr_en    = out_full_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign grant_id = grant_id_q;

endmodule
